xsnd_gen: RTL and testbench

//  Memory-mapped square-wave tone generator; a bus responder on the xaddr_decoder sel_snd port.

---
 rtl/xsnd_gen.sv | 147 ++++++++++++++
 tb/tb_xsnd_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xsnd_gen.sv
// Purpose : memory-mapped square-wave tone generator (HALFP high / HALFP low, DUR periods).
// Latency : register writes commit on the sel&we edge; reads are combinational, zero latency.
// Backpr. : none -- single-cycle bus responder, every access is accepted immediately.
//
// Ports:
//   clk, rst_n        core clock (rising edge), asynchronous active-low reset
//   sel, we, addr     bus select, write enable, word offset (0 CTRL, 1 HALFP, 2 DUR, 3 REMAIN)
//   data_in/data_out  write data / read data (data_out is 0 whenever sel=0)
//   snd_out           square-wave output
//   done_irq          level copy of the DONE flag
module xsnd_gen #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int HP_W   = 16,
    parameter int DUR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              snd_out,
    output logic              done_irq
);

    localparam int CFG_W = (HP_W > DUR_W) ? HP_W : DUR_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t            state_q;
    logic              snd_q;
    logic              done_q;
    logic              done_d;
    logic [HP_W-1:0]   halfp_q;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  remain_q;
    logic [HP_W-1:0]   cnt_q;

    logic              wr;
    logic              ctrl_wr;
    logic              start_w;
    logic              stop_w;
    logic              clr_w;
    logic              cfg_ok;
    logic              tone_end;
    logic              done_set;
    logic [HP_W-1:0]   reload;
    logic [DATA_W-1:0] rd_dat;
    logic              unused_data;

    assign wr       = sel & we;
    assign ctrl_wr  = wr & (addr == ADDR_W'(0));
    assign start_w  = ctrl_wr & data_in[0];
    assign stop_w   = ctrl_wr & data_in[1];
    assign clr_w    = ctrl_wr & data_in[2];
    assign cfg_ok   = (halfp_q != '0) && (dur_q != '0);
    assign reload   = halfp_q - HP_W'(1);

    // The tone ends when the last low half expires; REMAIN already reached 0 at
    // the preceding high->low toggle, so the final low half is still played out.
    assign tone_end = (state_q == ST_PLAY) && !start_w && !stop_w &&
                      (cnt_q == '0) && !snd_q && (remain_q == '0);

    assign done_set = (start_w && !stop_w && !cfg_ok) || tone_end;

    // Set has priority over a coincident DONE_CLR.
    assign done_d   = done_set ? 1'b1 : (clr_w ? 1'b0 : done_q);

    assign unused_data = ^data_in[DATA_W-1:CFG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            snd_q    <= 1'b0;
            done_q   <= 1'b0;
            halfp_q  <= '0;
            dur_q    <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= done_d;

            if (wr && (addr == ADDR_W'(1))) halfp_q <= data_in[HP_W-1:0];
            if (wr && (addr == ADDR_W'(2))) dur_q   <= data_in[DUR_W-1:0];

            if (stop_w) begin
                // STOP beats a simultaneous START; in IDLE it changes nothing.
                if (state_q == ST_PLAY) begin
                    state_q  <= ST_IDLE;
                    snd_q    <= 1'b0;
                    remain_q <= '0;
                    cnt_q    <= '0;
                end
            end else if (start_w) begin
                if (cfg_ok) begin
                    state_q  <= ST_PLAY;
                    snd_q    <= 1'b1;
                    cnt_q    <= reload;
                    remain_q <= dur_q;
                end else begin
                    state_q  <= ST_IDLE;
                    snd_q    <= 1'b0;
                    cnt_q    <= '0;
                    remain_q <= '0;
                end
            end else if (state_q == ST_PLAY) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - HP_W'(1);
                end else if (snd_q) begin
                    // High half done: one period fewer to go.
                    snd_q    <= 1'b0;
                    cnt_q    <= reload;
                    remain_q <= remain_q - DUR_W'(1);
                end else if (remain_q == '0) begin
                    state_q <= ST_IDLE;
                end else begin
                    snd_q <= 1'b1;
                    cnt_q <= reload;
                end
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        case (addr)
            ADDR_W'(0): begin
                rd_dat[0] = (state_q == ST_PLAY);
                rd_dat[1] = done_q;
            end
            ADDR_W'(1): rd_dat[HP_W-1:0]  = halfp_q;
            ADDR_W'(2): rd_dat[DUR_W-1:0] = dur_q;
            ADDR_W'(3): rd_dat[DUR_W-1:0] = remain_q;
            default:    rd_dat = '0;
        endcase
    end

    assign data_out = sel ? rd_dat : '0;
    assign snd_out  = snd_q;
    assign done_irq = done_q;

endmodule

// File: tb/tb_xsnd_gen.sv
// Purpose : directed + randomized bench for xsnd_gen against a waveform-queue model.
// Latency : one bus access per clock; outputs sampled 1 ns after each rising edge.
// Backpr. : none -- the DUT accepts every access.
module tb_xsnd_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        snd_out;
    logic        done_irq;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the expected waveform is a queue of output levels, one per
    // clock, refilled a whole half-period at a time.
    bit m_busy;
    bit m_done;
    bit m_high;
    int m_halfp;
    int m_dur;
    int m_remain;
    bit m_wave[$];

    xsnd_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .snd_out  (snd_out),
        .done_irq (done_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_busy = 0; m_done = 0; m_high = 0;
        m_halfp = 0; m_dur = 0; m_remain = 0;
        m_wave.delete();
    endfunction

    function automatic void m_fill(input bit lvl);
        for (int i = 0; i < m_halfp; i++) m_wave.push_back(lvl);
    endfunction

    function automatic void m_step(input bit s, input bit w, input logic [1:0] a, input logic [31:0] d);
        bit ctl, st, sp, cl, nd;
        ctl = s && w && (a == 2'd0);
        st  = ctl && d[0];
        sp  = ctl && d[1];
        cl  = ctl && d[2];
        nd  = m_done;
        if (cl) nd = 0;
        if (sp) begin
            if (m_busy) begin
                m_busy = 0; m_remain = 0; m_wave.delete();
            end
        end else if (st) begin
            m_wave.delete();
            if (m_halfp != 0 && m_dur != 0) begin
                m_busy = 1; m_high = 1; m_remain = m_dur; m_fill(1'b1);
            end else begin
                m_busy = 0; m_remain = 0; nd = 1;
            end
        end else if (m_busy) begin
            void'(m_wave.pop_front());
            if (m_wave.size() == 0) begin
                if (m_high) begin
                    m_high = 0; m_remain--; m_fill(1'b0);
                end else if (m_remain == 0) begin
                    m_busy = 0; nd = 1;
                end else begin
                    m_high = 1; m_fill(1'b1);
                end
            end
        end
        m_done = nd;
        if (s && w && a == 2'd1) m_halfp = int'(d[15:0]);
        if (s && w && a == 2'd2) m_dur   = int'(d[15:0]);
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_done, m_busy};
            2'd1:    return 32'(m_halfp);
            2'd2:    return 32'(m_dur);
            default: return 32'(m_remain);
        endcase
    endfunction

    function automatic logic m_snd();
        return m_busy ? m_wave[0] : 1'b0;
    endfunction

    // One clock with the given bus access; checks outputs after the edge.
    task automatic cyc(input bit s, input bit w, input logic [1:0] a, input logic [31:0] d);
        sel = s; we = w; addr = a; data_in = d;
        @(posedge clk);
        m_step(s, w, a, d);
        #1;
        check("snd_out", {31'd0, snd_out}, {31'd0, m_snd()});
        check("done_irq", {31'd0, done_irq}, {31'd0, m_done});
        sel = 0; we = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1, 1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 2'd0, 32'd0);
    endtask

    // Combinational read checked against the model, then data_out=0 with sel=0.
    task automatic rd(input logic [1:0] a);
        sel = 1; we = 0; addr = a;
        #1;
        check("rd_model", data_out, m_rd(a));
        sel = 0;
        #1;
        check("rd_nosel", data_out, 32'd0);
    endtask

    // Read checked against a fixed expected value.
    task automatic rdc(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sel = 1; we = 0; addr = a;
        #1;
        check(tag, data_out, exp);
        sel = 0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        m_reset();
        check("rst_snd", {31'd0, snd_out}, 32'd0);
        check("rst_irq", {31'd0, done_irq}, 32'd0);
        for (int a = 0; a < 4; a++) rdc("rst_reg", 2'(a), 32'd0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin : main
        logic [11:0] pat12;
        logic [4:0]  pat5;
        logic [7:0]  pat8;
        logic [31:0] junk;
        int          r;

        sel = 0; we = 0; addr = 0; data_in = 0; rst_n = 1;
        m_reset();
        #3;
        do_reset();

        // T2 basic tone
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd1);
        pat12[11] = snd_out;
        for (int i = 10; i >= 0; i--) begin
            idle(1);
            pat12[i] = snd_out;
        end
        check("t2_pattern", {20'd0, pat12}, {20'd0, 12'b111000111000});
        idle(1);
        check("t2_irq", {31'd0, done_irq}, 32'd1);
        rdc("t2_ctrl", 2'd0, 32'd2);
        rdc("t2_remain", 2'd3, 32'd0);

        // T3 zero config
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd5);
        wr(2'd0, 32'd5);
        check("t3_done", {31'd0, done_irq}, 32'd1);
        rdc("t3_ctrl", 2'd0, 32'd2);
        idle(3);
        check("t3_quiet", {31'd0, snd_out}, 32'd0);

        // T4 stop / restart
        wr(2'd1, 32'd4);
        wr(2'd2, 32'd10);
        wr(2'd0, 32'd5);
        idle(13);
        wr(2'd0, 32'd2);
        check("t4_snd", {31'd0, snd_out}, 32'd0);
        rdc("t4_remain", 2'd3, 32'd0);
        rdc("t4_ctrl", 2'd0, 32'd0);
        wr(2'd0, 32'd1);
        rdc("t4_remain10", 2'd3, 32'd10);
        pat5[4] = snd_out;
        for (int i = 3; i >= 0; i--) begin
            idle(1);
            pat5[i] = snd_out;
        end
        check("t4_first_high", {27'd0, pat5}, {27'd0, 5'b11110});

        // T5 collisions
        wr(2'd0, 32'd3);
        rdc("t5_start_stop", 2'd0, 32'd0);
        wr(2'd2, 32'd0);
        wr(2'd0, 32'd1);
        rdc("t5_done_set", 2'd0, 32'd2);
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'd5);
        rdc("t5_clr_start", 2'd0, 32'd1);
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd1);
        idle(1);
        wr(2'd0, 32'd4);
        rdc("t5_set_wins", 2'd0, 32'd2);

        // T6 live HALFP
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd1);
        pat8[7] = snd_out;
        wr(2'd1, 32'd5);
        pat8[6] = snd_out;
        for (int i = 5; i >= 0; i--) begin
            idle(1);
            pat8[i] = snd_out;
        end
        check("t6_pattern", {24'd0, pat8}, {24'd0, 8'b11000001});
        rd(2'd1);

        // T1 reset mid-play, then randomized traffic against the model
        idle(2);
        do_reset();
        for (int it = 0; it < 500; it++) begin
            junk = $urandom;
            r = $urandom_range(0, 9);
            if (it == 250) begin
                wr(2'd1, 32'd3); wr(2'd2, 32'd4); wr(2'd0, 32'd1); idle(5);
                do_reset();
            end else if (r < 2) begin
                wr(2'd1, {junk[31:16], 16'(m_busy ? $urandom_range(1, 5) : $urandom_range(0, 5))});
            end else if (r == 2) begin
                wr(2'd2, {junk[31:16], 16'($urandom_range(0, 4))});
            end else if (r < 5) begin
                wr(2'd0, {junk[31:3], 3'($urandom_range(0, 7))});
            end else if (r == 5) begin
                wr(2'd3, junk);
            end else begin
                idle(1);
            end
            rd(2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
